// File: rtl/ib_00_sub.sv
// Port-00 input buffer: FWFT FIFO of flits feeding the routing stage.
// Optional sticky overflow detection under `IB_OVF_DET_EN.
module ib_00_sub #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                ib_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out,
  output logic                ovf_err
);

  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic [WIDTH:0]      count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign ready_out = ~full;
  assign valid_out = ~empty;

  assign push = valid_in & ~full;
  assign pop  = rc_ready & ~empty;

  // Zero the head while empty so stale memory never leaks out.
  assign data_out     = empty ? '0 : mem[rd_ptr];
  assign pressure_out = count;

  always_ff @(posedge ib_clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge ib_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IB_OVF_DET_EN
  logic ovf_q;

  always_ff @(posedge ib_clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (valid_in & full & ~pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule
